skin_detect_ctrl: RTL and testbench

SKIN_DETECT_CTRL -- requirements
Module: skin_detect_ctrl

---
 rtl/skin_ctrl_pkg.sv | 59 +++++
 rtl/skin_frame_timer.sv | 71 +++++++
 rtl/skin_detect_ctrl.sv | 129 ++++++++++++
 tb/tb_skin_detect_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/skin_ctrl_pkg.sv
// Shared definitions for the skin-detect control block: register map, reset thresholds,
// CTRL bit layout, FSM states and the threshold/control register set.
package skin_ctrl_pkg;

  localparam logic [2:0] AddrCbLow  = 3'd0;
  localparam logic [2:0] AddrCbHigh = 3'd1;
  localparam logic [2:0] AddrCrLow  = 3'd2;
  localparam logic [2:0] AddrCrHigh = 3'd3;
  localparam logic [2:0] AddrCtrl   = 3'd4;
  localparam logic [2:0] AddrErrClr = 3'd5;

  localparam logic [7:0] DefCbLow  = 8'd77;
  localparam logic [7:0] DefCbHigh = 8'd127;
  localparam logic [7:0] DefCrLow  = 8'd133;
  localparam logic [7:0] DefCrHigh = 8'd173;

  localparam int unsigned CtrlEnableBit = 0;
  localparam int unsigned CtrlBypassBit = 1;

  typedef enum logic [1:0] {StIdle, StWaitSof, StInFrame} skin_state_e;

  typedef struct packed {
    logic [7:0] cb_low;
    logic [7:0] cb_high;
    logic [7:0] cr_low;
    logic [7:0] cr_high;
    logic       enable;
    logic       bypass;
  } skin_cfg_t;

  localparam skin_cfg_t CfgDefault = '{
    cb_low:  DefCbLow,
    cb_high: DefCbHigh,
    cr_low:  DefCrLow,
    cr_high: DefCrHigh,
    enable:  1'b1,
    bypass:  1'b0
  };

  // Addresses outside the threshold/CTRL range leave the register set untouched.
  function automatic skin_cfg_t cfg_write(input skin_cfg_t cfg, input logic [2:0] addr,
                                          input logic [7:0] data);
    skin_cfg_t res;
    res = cfg;
    case (addr)
      AddrCbLow:  res.cb_low  = data;
      AddrCbHigh: res.cb_high = data;
      AddrCrLow:  res.cr_low  = data;
      AddrCrHigh: res.cr_high = data;
      AddrCtrl: begin
        res.enable = data[CtrlEnableBit];
        res.bypass = data[CtrlBypassBit];
      end
      default: ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/skin_frame_timer.sv
// Beat/line counters for the monitored stream; flags end-of-line length, frame
// completion and an SOF arriving inside a frame.
module skin_frame_timer
  import skin_ctrl_pkg::*;
#(
  parameter int unsigned H_BEATS = 480,
  parameter int unsigned V_LINES = 1080
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_beat,
  input  logic i_sof,
  input  logic i_last,
  input  logic i_in_frame,
  output logic o_eol,
  output logic o_eol_ok,
  output logic o_frame_done,
  output logic o_sof_early
);

  localparam int unsigned BeatW = ($clog2(H_BEATS + 1) > 9) ? $clog2(H_BEATS + 1) : 9;
  localparam int unsigned LineW = ($clog2(V_LINES + 1) > 1) ? $clog2(V_LINES + 1) : 1;

  logic [BeatW-1:0] beat_q, beat_d, beat_base;
  logic [LineW-1:0] line_q, line_d, line_base, line_inc;

  always_comb begin
    // An SOF beat restarts counting with itself as beat 0 of line 0.
    beat_base    = i_sof ? '0 : beat_q;
    line_base    = i_sof ? '0 : line_q;
    line_inc     = line_base + LineW'(1);
    beat_d       = beat_q;
    line_d       = line_q;
    o_eol        = 1'b0;
    o_eol_ok     = 1'b0;
    o_frame_done = 1'b0;
    o_sof_early  = i_beat & i_sof & i_in_frame;
    if (i_beat) begin
      if (i_last) begin
        o_eol    = 1'b1;
        o_eol_ok = (32'(beat_base) + 32'd1 == H_BEATS);
        beat_d   = '0;
        if (32'(line_inc) == V_LINES) begin
          o_frame_done = 1'b1;
          line_d       = '0;
        end else begin
          line_d = line_inc;
        end
      end else begin
        beat_d = beat_base + BeatW'(1);
        line_d = line_base;
      end
    end
    if (i_clr) begin
      beat_d = '0;
      line_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beat_q <= '0;
      line_q <= '0;
    end else begin
      beat_q <= beat_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/skin_detect_ctrl.sv
// Control plane for the skin-detect datapath: shadow/active threshold registers with
// frame-synchronous commit, stream framing FSM, frame counter and sticky error flags.
module skin_detect_ctrl
  import skin_ctrl_pkg::*;
#(
  parameter int unsigned H_BEATS = 480,
  parameter int unsigned V_LINES = 1080
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cfg_wr,
  input  logic [2:0]  i_cfg_addr,
  input  logic [7:0]  i_cfg_wdata,
  input  logic        i_cfg_commit,
  input  logic        i_valid,
  input  logic        i_user,
  input  logic        i_last,
  output logic [7:0]  o_cb_low,
  output logic [7:0]  o_cb_high,
  output logic [7:0]  o_cr_low,
  output logic [7:0]  o_cr_high,
  output logic        o_enable,
  output logic        o_bypass,
  output logic        o_cfg_pending,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt,
  output logic        o_err_line,
  output logic        o_err_frame
);

  skin_state_e state_q, state_d;
  skin_cfg_t   shadow_q, shadow_d, active_q, active_d;
  logic        pending_q, pending_d;
  logic [15:0] frame_q, frame_d;
  logic        err_line_q, err_line_d, err_frame_q, err_frame_d;
  logic        sof_beat, beat_en, apply, err_clr;
  logic        eol, eol_ok, frame_done, sof_early;

  // Shadow is updated first so a same-cycle write is included in any commit.
  always_comb begin
    shadow_d  = i_cfg_wr ? cfg_write(shadow_q, i_cfg_addr, i_cfg_wdata) : shadow_q;
    sof_beat  = i_valid & i_user & (state_q != StIdle);
    apply     = 1'b0;
    pending_d = pending_q;
    if (state_q == StIdle) begin
      apply = i_cfg_commit;
    end else if (pending_q && sof_beat) begin
      apply     = 1'b1;
      pending_d = i_cfg_commit;
    end else if (i_cfg_commit) begin
      pending_d = 1'b1;
    end
    active_d = apply ? shadow_d : active_q;
    if (!active_d.enable) pending_d = 1'b0;
  end

  assign beat_en = i_valid & ((state_q == StInFrame) | ((state_q == StWaitSof) & i_user));
  assign err_clr = i_cfg_wr & (i_cfg_addr == AddrErrClr);

  skin_frame_timer #(
    .H_BEATS (H_BEATS),
    .V_LINES (V_LINES)
  ) u_timer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clr        (~active_d.enable),
    .i_beat       (beat_en),
    .i_sof        (i_user),
    .i_last       (i_last),
    .i_in_frame   (state_q == StInFrame),
    .o_eol        (eol),
    .o_eol_ok     (eol_ok),
    .o_frame_done (frame_done),
    .o_sof_early  (sof_early)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (active_d.enable) state_d = StWaitSof;
      StWaitSof: if (beat_en) state_d = StInFrame;
      StInFrame: ;
      default:   state_d = StIdle;
    endcase
    if (frame_done) state_d = StWaitSof;
    if (!active_d.enable) state_d = StIdle;
  end

  always_comb begin
    frame_d     = frame_done ? frame_q + 16'd1 : frame_q;
    err_line_d  = (err_line_q & ~err_clr) | (eol & ~eol_ok);
    err_frame_d = (err_frame_q & ~err_clr) | sof_early;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StWaitSof;
      shadow_q    <= CfgDefault;
      active_q    <= CfgDefault;
      pending_q   <= 1'b0;
      frame_q     <= '0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      frame_q     <= frame_d;
      err_line_q  <= err_line_d;
      err_frame_q <= err_frame_d;
    end
  end

  always_comb begin
    o_cb_low      = active_q.cb_low;
    o_cb_high     = active_q.cb_high;
    o_cr_low      = active_q.cr_low;
    o_cr_high     = active_q.cr_high;
    o_enable      = active_q.enable;
    o_bypass      = active_q.bypass;
    o_cfg_pending = pending_q;
    o_busy        = (state_q == StInFrame);
    o_frame_cnt   = frame_q;
    o_err_line    = err_line_q;
    o_err_frame   = err_frame_q;
  end

endmodule

// File: tb/tb_skin_detect_ctrl.sv
// Bench for skin_detect_ctrl on a reduced frame geometry, checked against a
// transaction-level model of the register set and frame timing.
module tb_skin_detect_ctrl;
  import skin_ctrl_pkg::*;

  localparam int unsigned H = 8;
  localparam int unsigned V = 4;
  localparam int MIdle = 0, MWait = 1, MIn = 2;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_cfg_wr = 1'b0, i_cfg_commit = 1'b0;
  logic [2:0]  i_cfg_addr = '0;
  logic [7:0]  i_cfg_wdata = '0;
  logic        i_valid = 1'b0, i_user = 1'b0, i_last = 1'b0;
  logic [7:0]  o_cb_low, o_cb_high, o_cr_low, o_cr_high;
  logic        o_enable, o_bypass, o_cfg_pending, o_busy, o_err_line, o_err_frame;
  logic [15:0] o_frame_cnt;

  int checks = 0;
  int errors = 0;

  skin_detect_ctrl #(.H_BEATS(H), .V_LINES(V)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cfg_wr(i_cfg_wr), .i_cfg_addr(i_cfg_addr),
    .i_cfg_wdata(i_cfg_wdata), .i_cfg_commit(i_cfg_commit), .i_valid(i_valid),
    .i_user(i_user), .i_last(i_last), .o_cb_low(o_cb_low), .o_cb_high(o_cb_high),
    .o_cr_low(o_cr_low), .o_cr_high(o_cr_high), .o_enable(o_enable), .o_bypass(o_bypass),
    .o_cfg_pending(o_cfg_pending), .o_busy(o_busy), .o_frame_cnt(o_frame_cnt),
    .o_err_line(o_err_line), .o_err_frame(o_err_frame)
  );

  always #5 i_clk = ~i_clk;

  // Reference model state
  logic [7:0]  sh[4], ac[4];
  bit          sh_en, sh_by, ac_en, ac_by, m_pending, m_el, m_ef;
  int          m_mode, m_beat, m_line;
  logic [15:0] m_frames;

  task automatic model_reset();
    sh = '{8'd77, 8'd127, 8'd133, 8'd173};
    ac = sh;
    sh_en = 1; sh_by = 0; ac_en = 1; ac_by = 0;
    m_pending = 0; m_el = 0; m_ef = 0;
    m_mode = MWait; m_beat = 0; m_line = 0; m_frames = 0;
  endtask

  task automatic model_step(input bit v, input bit u, input bit l, input bit wr,
                            input logic [2:0] a, input logic [7:0] d, input bit cm);
    bit clr, apply, sof;
    clr = 0; apply = 0;
    if (wr) begin
      if (a < 4) sh[a[1:0]] = d;
      else if (a == 4) begin sh_en = d[0]; sh_by = d[1]; end
      else if (a == 5) clr = 1;
    end
    sof = v && u && (m_mode != MIdle);
    if (m_mode == MIdle) apply = cm;
    else if (m_pending && sof) begin apply = 1; m_pending = cm; end
    else if (cm) m_pending = 1;
    if (clr) begin m_el = 0; m_ef = 0; end
    if (v && (m_mode == MIn || (m_mode == MWait && u))) begin
      if (u) begin
        if (m_mode == MIn) m_ef = 1;
        m_mode = MIn; m_beat = 0; m_line = 0;
      end
      if (l) begin
        if (m_beat + 1 != int'(H)) m_el = 1;
        m_beat = 0;
        m_line++;
        if (m_line == int'(V)) begin m_frames++; m_line = 0; m_mode = MWait; end
      end else begin
        m_beat++;
      end
    end
    if (apply) begin ac = sh; ac_en = sh_en; ac_by = sh_by; end
    if (!ac_en) begin m_mode = MIdle; m_beat = 0; m_line = 0; m_pending = 0; end
    else if (m_mode == MIdle) m_mode = MWait;
  endtask

  task automatic cyc(input bit v, input bit u, input bit l, input bit wr,
                     input logic [2:0] a, input logic [7:0] d, input bit cm);
    i_valid = v; i_user = u; i_last = l;
    i_cfg_wr = wr; i_cfg_addr = a; i_cfg_wdata = d; i_cfg_commit = cm;
    @(posedge i_clk);
    model_step(v, u, l, wr, a, d, cm);
    #1;
    i_valid = 0; i_cfg_wr = 0; i_cfg_commit = 0;
  endtask

  // One accepted beat preceded by a random number of non-valid cycles with noisy side-band.
  task automatic beat(input bit u, input bit l);
    int gaps;
    gaps = $urandom_range(0, 2);
    for (int g = 0; g < gaps; g++) cyc(0, 1'($urandom), 1'($urandom), 0, 3'd0, 8'd0, 0);
    cyc(1, u, l, 0, 3'd0, 8'd0, 0);
  endtask

  task automatic send_line(input bit sof, input int n);
    for (int i = 0; i < n; i++) beat(sof && i == 0, i == n - 1);
  endtask

  task automatic send_lines(input int n);
    for (int i = 0; i < n; i++) send_line(0, H);
  endtask

  task automatic send_frame();
    send_line(1, H);
    send_lines(V - 1);
  endtask

  task automatic do_reset();
    i_rst = 1;
    repeat (2) @(posedge i_clk);
    model_reset();
    #1;
    i_rst = 0;
  endtask

  task automatic test_reset();
    send_line(1, H);
    beat(0, 0);
    do_reset();
    checks++; if (o_cb_low !== 8'd77) begin errors++; $display("FAIL reset_cb_low: got %0d expected 77", o_cb_low); end
    checks++; if (o_cb_high !== 8'd127) begin errors++; $display("FAIL reset_cb_high: got %0d expected 127", o_cb_high); end
    checks++; if (o_cr_low !== 8'd133) begin errors++; $display("FAIL reset_cr_low: got %0d expected 133", o_cr_low); end
    checks++; if (o_cr_high !== 8'd173) begin errors++; $display("FAIL reset_cr_high: got %0d expected 173", o_cr_high); end
    checks++; if ({o_enable, o_bypass} !== 2'b10) begin errors++; $display("FAIL reset_ctrl: got %b expected 10", {o_enable, o_bypass}); end
    checks++; if ({o_cfg_pending, o_busy, o_err_line, o_err_frame} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {o_cfg_pending, o_busy, o_err_line, o_err_frame}); end
    checks++; if (o_frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", o_frame_cnt); end
  endtask

  task automatic test_frames();
    for (int f = 0; f < 2; f++) begin
      send_frame();
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL frame_busy_after_eol: got %b expected 0", o_busy); end
    end
    checks++; if (o_frame_cnt !== 16'd2) begin errors++; $display("FAIL frame_cnt_two: got %0d expected 2", o_frame_cnt); end
    checks++; if ({o_err_line, o_err_frame} !== 2'b00) begin errors++; $display("FAIL frame_clean_errs: got %b expected 00", {o_err_line, o_err_frame}); end
  endtask

  task automatic test_threshold();
    send_line(1, H);
    beat(0, 0);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL thr_busy_mid: got %b expected 1", o_busy); end
    cyc(0, 0, 0, 1, AddrCbLow, 8'd90, 1);
    checks++; if ({o_cb_low, o_cfg_pending} !== {8'd77, 1'b1}) begin errors++; $display("FAIL thr_after_commit: got %0d/%b expected 77/1", o_cb_low, o_cfg_pending); end
    for (int i = 1; i < int'(H); i++) beat(0, i == int'(H) - 1);
    send_lines(V - 2);
    checks++; if (o_cb_low !== 8'd77) begin errors++; $display("FAIL thr_before_sof: got %0d expected 77", o_cb_low); end
    beat(1, 0);
    checks++; if ({o_cb_low, o_cfg_pending} !== {8'd90, 1'b0}) begin errors++; $display("FAIL thr_at_sof: got %0d/%b expected 90/0", o_cb_low, o_cfg_pending); end
    for (int i = 1; i < int'(H); i++) beat(0, i == int'(H) - 1);
    send_lines(V - 1);
  endtask

  task automatic test_short_line();
    logic [15:0] f0;
    f0 = m_frames;
    send_line(1, H - 1);
    checks++; if ({o_err_line, o_err_frame} !== 2'b10) begin errors++; $display("FAIL short_err_set: got %b expected 10", {o_err_line, o_err_frame}); end
    send_lines(2);
    checks++; if (o_err_line !== 1'b1) begin errors++; $display("FAIL short_err_sticky: got %b expected 1", o_err_line); end
    cyc(0, 0, 0, 1, AddrErrClr, 8'd0, 0);
    checks++; if (o_err_line !== 1'b0) begin errors++; $display("FAIL short_err_clr: got %b expected 0", o_err_line); end
    for (int i = 0; i < int'(H) - 2; i++) beat(0, 0);
    cyc(1, 0, 1, 1, AddrErrClr, 8'd0, 0);
    checks++; if (o_err_line !== 1'b1) begin errors++; $display("FAIL short_err_clr_collision: got %b expected 1", o_err_line); end
    checks++; if (o_frame_cnt !== f0 + 16'd1) begin errors++; $display("FAIL short_frame_cnt: got %0d expected %0d", o_frame_cnt, f0 + 16'd1); end
    cyc(0, 0, 0, 1, AddrErrClr, 8'd0, 0);
  endtask

  task automatic test_premature_sof();
    logic [15:0] f0;
    f0 = m_frames;
    send_line(1, H);
    send_lines(V / 2 - 1);
    beat(1, 0);
    checks++; if ({o_err_frame, o_busy} !== 2'b11) begin errors++; $display("FAIL early_sof_flag: got %b expected 11", {o_err_frame, o_busy}); end
    for (int i = 1; i < int'(H); i++) beat(0, i == int'(H) - 1);
    send_lines(V - 1);
    checks++; if (o_frame_cnt !== f0 + 16'd1) begin errors++; $display("FAIL early_sof_frame_cnt: got %0d expected %0d", o_frame_cnt, f0 + 16'd1); end
    checks++; if ({o_err_line, o_busy} !== 2'b00) begin errors++; $display("FAIL early_sof_tail: got %b expected 00", {o_err_line, o_busy}); end
    cyc(0, 0, 0, 1, AddrErrClr, 8'd0, 0);
  endtask

  task automatic test_disable();
    logic [15:0] f0;
    send_line(1, H);
    cyc(0, 0, 0, 1, AddrCtrl, 8'd0, 1);
    checks++; if ({o_enable, o_cfg_pending} !== 2'b11) begin errors++; $display("FAIL dis_pending: got %b expected 11", {o_enable, o_cfg_pending}); end
    send_lines(V - 1);
    beat(1, 0);
    checks++; if ({o_enable, o_busy, o_cfg_pending} !== 3'b000) begin errors++; $display("FAIL dis_applied: got %b expected 000", {o_enable, o_busy, o_cfg_pending}); end
    f0 = m_frames;
    send_frame();
    checks++; if (o_frame_cnt !== f0) begin errors++; $display("FAIL dis_frozen: got %0d expected %0d", o_frame_cnt, f0); end
    cyc(0, 0, 0, 1, AddrCrHigh, 8'd180, 1);
    checks++; if ({o_cr_high, o_cfg_pending} !== {8'd180, 1'b0}) begin errors++; $display("FAIL dis_idle_commit: got %0d/%b expected 180/0", o_cr_high, o_cfg_pending); end
    cyc(0, 0, 0, 1, AddrCtrl, 8'd1, 1);
    checks++; if ({o_enable, o_busy} !== 2'b10) begin errors++; $display("FAIL dis_reenable: got %b expected 10", {o_enable, o_busy}); end
  endtask

  task automatic test_collision();
    logic [7:0] nv, old;
    nv  = 8'(128 + $urandom_range(0, 126));
    old = ac[1];
    cyc(0, 0, 0, 1, AddrCbHigh, nv, 0);
    cyc(1, 1, 0, 0, 3'd0, 8'd0, 1);
    checks++; if ({o_cb_high, o_cfg_pending} !== {old, 1'b1}) begin errors++; $display("FAIL coll_at_sof: got %0d/%b expected %0d/1", o_cb_high, o_cfg_pending, old); end
    for (int i = 1; i < int'(H); i++) beat(0, i == int'(H) - 1);
    send_lines(V - 1);
    checks++; if (o_cb_high !== old) begin errors++; $display("FAIL coll_frame_hold: got %0d expected %0d", o_cb_high, old); end
    beat(1, 0);
    checks++; if ({o_cb_high, o_cfg_pending} !== {nv, 1'b0}) begin errors++; $display("FAIL coll_next_sof: got %0d/%b expected %0d/0", o_cb_high, o_cfg_pending, nv); end
    for (int i = 1; i < int'(H); i++) beat(0, i == int'(H) - 1);
    send_lines(V - 1);
  endtask

  task automatic test_random();
    logic [53:0] exp_v, got_v;
    bit v, u, l, wr, cm;
    logic [2:0] a;
    logic [7:0] d;
    for (int n = 0; n < 3000; n++) begin
      v  = ($urandom_range(0, 9) < 7);
      u  = ($urandom_range(0, 19) == 0);
      l  = ($urandom_range(0, 7) == 0);
      wr = ($urandom_range(0, 19) == 0);
      cm = ($urandom_range(0, 29) == 0);
      a  = 3'($urandom_range(0, 7));
      d  = 8'($urandom);
      if (a == AddrCtrl) d[0] = ($urandom_range(0, 5) != 0);
      cyc(v, u, l, wr, a, d, cm);
      if (n % 10 == 9) begin
        exp_v = {ac[0], ac[1], ac[2], ac[3], ac_en, ac_by, m_pending, 1'(m_mode == MIn),
                 m_frames, m_el, m_ef};
        got_v = {o_cb_low, o_cb_high, o_cr_low, o_cr_high, o_enable, o_bypass, o_cfg_pending,
                 o_busy, o_frame_cnt, o_err_line, o_err_frame};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL random_state cycle %0d: got %h expected %h", n, got_v, exp_v);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    do_reset();
    test_reset();
    test_frames();
    test_threshold();
    test_short_line();
    test_premature_sof();
    test_disable();
    test_collision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
